// File: rtl/imem_sync.sv
// Synchronous instruction memory: post-reset clear, registered fetch with fault flags, runtime program port.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity plus a parity_err output).

module imem_sync #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_BITS = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              misaligned,
  output logic              out_of_range,
  output logic              busy,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = 33;
`else
  localparam int unsigned MEM_W = 32;
`endif

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_PROG} state_e;

  // Stored word encoding: parity bit (when enabled) above the data.
  function automatic logic [MEM_W-1:0] enc(input logic [31:0] d);
`ifdef IMEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  state_e                  state_q, state_d;
  logic [DEPTH_BITS-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    valid_q, valid_d;
  logic                    mis_q, mis_d;
  logic                    oor_q, oor_d;
  logic                    busy_q, busy_d;
  logic [MEM_W-1:0]        mem_q [DEPTH];
  logic [MEM_W-1:0]        rd_word_q;

  logic                    wr_en;
  logic [DEPTH_BITS-1:0]   wr_idx;
  logic [MEM_W-1:0]        wr_word;
  logic                    rd_en;
  logic                    ld_nop;

  logic [DEPTH_BITS-1:0]   pc_idx;
  logic [DEPTH_BITS-1:0]   prog_idx;
  logic                    pc_mis;
  logic                    pc_oor;
  logic                    prog_oor;
  logic                    unused_prog_lsb;

  assign pc_idx          = pc[DEPTH_BITS+1:2];
  assign prog_idx        = prog_addr[DEPTH_BITS+1:2];
  assign pc_mis          = (pc[1:0] != 2'b00);
  assign pc_oor          = (pc[ADDR_W-1:DEPTH_BITS+2] != '0);
  assign prog_oor        = (prog_addr[ADDR_W-1:DEPTH_BITS+2] != '0);
  assign unused_prog_lsb = ^prog_addr[1:0];

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      oor_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
      oor_q     <= oor_d;
      busy_q    <= busy_d;
    end
  end

  // Next state; the clear counter wraps back to 0 as CLEAR ends
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + DEPTH_BITS'(1);
        if (clr_cnt_q == DEPTH_BITS'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  if (prog_en)  state_d = ST_PROG;
      ST_PROG: if (!prog_en) state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Memory port control and output next values; prog_en wins over a same-cycle fetch
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = clr_cnt_q;
    wr_word = enc(NOP_WORD);
    rd_en   = 1'b0;
    ld_nop  = 1'b0;
    valid_d = 1'b0;
    mis_d   = mis_q;
    oor_d   = oor_q;
    busy_d  = (state_d != ST_RUN);
    case (state_q)
      ST_CLEAR: wr_en = 1'b1;
      ST_RUN: begin
        if (req && !prog_en) begin
          valid_d = 1'b1;
          mis_d   = pc_mis;
          oor_d   = pc_oor;
          if (pc_mis || pc_oor) ld_nop = 1'b1;
          else                  rd_en  = 1'b1;
        end
      end
      ST_PROG: begin
        if (prog_we && !prog_oor) begin
          wr_en   = 1'b1;
          wr_idx  = prog_idx;
          wr_word = enc(prog_data);
        end
      end
      default: ;
    endcase
  end

  // Block RAM: single write port, registered read (reads and writes never share a cycle)
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst)         rd_word_q <= enc(NOP_WORD);
    else if (rd_en)  rd_word_q <= mem_q[pc_idx];
    else if (ld_nop) rd_word_q <= enc(NOP_WORD);
  end

`ifdef IMEM_PARITY_EN
  // Fault words are loaded with correct parity, so a mismatch only comes from a stored word
  assign parity_err = ^rd_word_q;
  assign instr      = parity_err ? NOP_WORD : rd_word_q[31:0];
`else
  assign instr      = rd_word_q;
`endif

  assign instr_valid  = valid_q;
  assign misaligned   = mis_q;
  assign out_of_range = oor_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: clear timing, program/fetch, faults, collision, reset mid-operation.
// Build with IMEM_PARITY_EN defined to also exercise the parity path.

module tb_imem_sync;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W_A = 32'h03F8_05B7;
  localparam logic [31:0] W_B = 32'h0145_A803;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [15:0] pc = '0;
  logic [31:0] instr;
  logic        instr_valid, misaligned, out_of_range, busy;
  logic        prog_en = 1'b0;
  logic        prog_we = 1'b0;
  logic [15:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
`endif

  imem_sync dut (
    .clk(clk), .rst(rst), .req(req), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .misaligned(misaligned),
    .out_of_range(out_of_range), .busy(busy),
    .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
`ifdef IMEM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        mis;
    logic        oor;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] i, input logic m, input logic o);
    exp_t e;
    e.instr = i; e.mis = m; e.oor = o;
    sb.push_back(e);
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want 256", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({busy, instr_valid, misaligned, out_of_range, instr} !== {4'b1000, NOP}) begin
      errors++;
      $display("FAIL reset_state got busy=%b v=%b m=%b o=%b instr=%h want 1000 %h",
               busy, instr_valid, misaligned, out_of_range, instr, NOP);
    end
    rst = 1'b0;
    count_clear("reset_clear");
    req = 1'b1; pc = 16'h0008; push(NOP, 1'b0, 1'b0);
    step();
    req = 1'b0;
    begin
      exp_t e = sb.pop_front();
      checks++;
      if ({instr_valid, misaligned, out_of_range, instr} !== {1'b1, e.mis, e.oor, e.instr}) begin
        errors++;
        $display("FAIL idle_fetch got v=%b m=%b o=%b instr=%h want 1 %b %b %h",
                 instr_valid, misaligned, out_of_range, instr, e.mis, e.oor, e.instr);
      end
    end
    step();
    checks++;
    if ({instr_valid, instr} !== {1'b0, NOP}) begin
      errors++;
      $display("FAIL idle_hold got v=%b instr=%h want 0 %h", instr_valid, instr, NOP);
    end
  endtask

  task automatic test_program();
    prog_en = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL prog_busy got %b want 1", busy);
    end
    prog_we = 1'b1; prog_addr = 16'h0000; prog_data = W_A;
    step();
    prog_addr = 16'h0004; prog_data = W_B; prog_en = 1'b0;
    step();
    prog_we = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL prog_exit_busy got %b want 0", busy);
    end
    req = 1'b1; pc = 16'h0000; push(W_A, 1'b0, 1'b0);
    step();
    pc = 16'h0004; push(W_B, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      exp_t e = sb.pop_front();
      checks++;
      if ({instr_valid, misaligned, out_of_range, instr} !== {1'b1, e.mis, e.oor, e.instr}) begin
        errors++;
        $display("FAIL prog_fetch%0d got v=%b m=%b o=%b instr=%h want 1 %b %b %h",
                 k, instr_valid, misaligned, out_of_range, instr, e.mis, e.oor, e.instr);
      end
      if (k == 0) step();
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_faults();
    logic [15:0] pcs  [6] = '{16'h0000, 16'h0006, 16'h0004, 16'h0400, 16'h0402, 16'h03FC};
    logic [31:0] ins  [6] = '{W_A, NOP, W_B, NOP, NOP, NOP};
    logic        mis  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        oor  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pc = pcs[k];
      push(ins[k], mis[k], oor[k]);
      step();
      begin
        exp_t e = sb.pop_front();
        checks++;
        if ({instr_valid, misaligned, out_of_range, instr} !== {1'b1, e.mis, e.oor, e.instr}) begin
          errors++;
          $display("FAIL fault_pc%h got v=%b m=%b o=%b instr=%h want 1 %b %b %h",
                   pcs[k], instr_valid, misaligned, out_of_range, instr, e.mis, e.oor, e.instr);
        end
      end
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_collision();
    req = 1'b1; pc = 16'h0000; prog_en = 1'b1;
    step();
    req = 1'b0;
    checks++;
    if ({instr_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL collision got v=%b busy=%b want v=0 busy=1", instr_valid, busy);
    end
    prog_we = 1'b1; prog_addr = 16'h0800; prog_data = 32'hFFFF_FFFF; prog_en = 1'b0;
    step();
    prog_we = 1'b0;
    req = 1'b1; pc = 16'h0000; push(W_A, 1'b0, 1'b0);
    step();
    req = 1'b0;
    begin
      exp_t e = sb.pop_front();
      checks++;
      if ({instr_valid, instr} !== {1'b1, e.instr}) begin
        errors++;
        $display("FAIL oor_write got v=%b instr=%h want 1 %h", instr_valid, instr, e.instr);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_busy got %b want 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear("restart_clear");
    prog_en = 1'b1;
    step();
    prog_we = 1'b1; prog_addr = 16'h0010; prog_data = 32'hDEAD_BEEF;
    step();
    prog_we = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; prog_en = 1'b0;
    count_clear("prog_reset_clear");
    req = 1'b1; pc = 16'h0010; push(NOP, 1'b0, 1'b0);
    step();
    pc = 16'h0000; push(NOP, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      exp_t e = sb.pop_front();
      checks++;
      if ({instr_valid, instr} !== {1'b1, e.instr}) begin
        errors++;
        $display("FAIL lost_write%0d got v=%b instr=%h want 1 %h", k, instr_valid, instr, e.instr);
      end
      if (k == 0) step();
    end
    req = 1'b0;
    step();
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    prog_en = 1'b1;
    step();
    prog_we = 1'b1; prog_addr = 16'h0020; prog_data = 32'h0000_0001; prog_en = 1'b0;
    step();
    prog_we = 1'b0;
    dut.mem_q[8][32] = ~dut.mem_q[8][32];
    req = 1'b1; pc = 16'h0020; push(NOP, 1'b0, 1'b0);
    step();
    pc = 16'h0024; push(NOP, 1'b0, 1'b0);
    begin
      exp_t e = sb.pop_front();
      checks++;
      if ({parity_err, instr_valid, instr} !== {2'b11, e.instr}) begin
        errors++;
        $display("FAIL parity_bad got pe=%b v=%b instr=%h want 1 1 %h",
                 parity_err, instr_valid, instr, e.instr);
      end
    end
    step();
    req = 1'b0;
    begin
      exp_t e = sb.pop_front();
      checks++;
      if ({parity_err, instr_valid, instr} !== {2'b01, e.instr}) begin
        errors++;
        $display("FAIL parity_good got pe=%b v=%b instr=%h want 0 1 %h",
                 parity_err, instr_valid, instr, e.instr);
      end
    end
    step();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    test_reset();
    test_program();
    test_faults();
    test_collision();
    test_reset_mid();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
